// File: rtl/chan_pkg.sv
// Shared channel-model types and LFSR constants for the Gilbert-Elliott channel state controller.
package chan_pkg;

    typedef enum logic {
        CH_BAD  = 1'b0,
        CH_GOOD = 1'b1
    } chan_state_t;

    localparam int unsigned LFSR16_W    = 16;
    localparam logic [15:0] LFSR16_SEED = 16'hACE1;
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;

    // Right-shifting Galois step for x^16+x^14+x^13+x^11+1; never reaches zero from a non-zero seed.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = cur >> 1;
        return cur[0] ? (shifted ^ LFSR16_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, seeded on reset, stepping only when advance is high.
module lfsr16
    import chan_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    always_comb begin
        value_d = value_q;
        if (advance) begin
            value_d = lfsr16_next(value_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= LFSR16_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/channel_state_ctrl.sv
// Two-state (GOOD/BAD) Markov channel controller with minimum dwell, forcing and statistics.
module channel_state_ctrl
    import chan_pkg::*;
#(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [15:0]        p_gb,
    input  logic [15:0]        p_bg,
    input  logic [DWELL_W-1:0] min_dwell,
    input  logic               force_valid,
    input  logic               force_state,
    input  logic               clear_stats,
    output logic               state,
    output logic               state_change,
    output logic [CNT_W-1:0]   bad_cycles,
    output logic [15:0]        transitions
);

    localparam int unsigned TR_W = 16;

    chan_state_t        state_q,        state_d;
    logic [DWELL_W-1:0] dwell_q,        dwell_d;
    logic               state_change_q, state_change_d;
    logic [CNT_W-1:0]   bad_cycles_q,   bad_cycles_d;
    logic [TR_W-1:0]    transitions_q,  transitions_d;

    logic [15:0] lfsr_value;
    logic [15:0] threshold;
    logic        dwell_ok;
    logic        rand_hit;
    logic        changed;

    lfsr16 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (enable),
        .value   (lfsr_value)
    );

    // Random transition decision uses the LFSR value before this cycle's advance.
    always_comb begin
        threshold = (state_q == CH_GOOD) ? p_gb : p_bg;
        dwell_ok  = (dwell_q >= min_dwell);
        rand_hit  = enable && dwell_ok && (lfsr_value <= threshold);
    end

    // Next state and dwell: force beats random transition; everything else freezes while disabled.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (force_valid) begin
            state_d = force_state ? CH_GOOD : CH_BAD;
            dwell_d = '0;
        end else if (rand_hit) begin
            state_d = (state_q == CH_GOOD) ? CH_BAD : CH_GOOD;
            dwell_d = '0;
        end else if (enable) begin
            if (dwell_q != {DWELL_W{1'b1}}) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
        end
    end

    // Statistics: clear wins over increment, both counters saturate.
    always_comb begin
        changed        = (state_d != state_q);
        state_change_d = changed;
        bad_cycles_d   = bad_cycles_q;
        transitions_d  = transitions_q;
        if (clear_stats) begin
            bad_cycles_d  = '0;
            transitions_d = '0;
        end else begin
            if (enable && (state_q == CH_BAD) && (bad_cycles_q != {CNT_W{1'b1}})) begin
                bad_cycles_d = bad_cycles_q + CNT_W'(1);
            end
            if (changed && (transitions_q != {TR_W{1'b1}})) begin
                transitions_d = transitions_q + TR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= CH_GOOD;
            dwell_q        <= '0;
            state_change_q <= 1'b0;
            bad_cycles_q   <= '0;
            transitions_q  <= '0;
        end else begin
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            state_change_q <= state_change_d;
            bad_cycles_q   <= bad_cycles_d;
            transitions_q  <= transitions_d;
        end
    end

    assign state        = state_q;
    assign state_change = state_change_q;
    assign bad_cycles   = bad_cycles_q;
    assign transitions  = transitions_q;

endmodule

// File: tb/tb_channel_state_ctrl.sv
// Directed, table-driven bench for channel_state_ctrl with hand-computed expectations.
module tb_channel_state_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] p_gb;
    logic [15:0] p_bg;
    logic [7:0]  min_dwell;
    logic        force_valid;
    logic        force_state;
    logic        clear_stats;
    logic        state;
    logic        state_change;
    logic [31:0] bad_cycles;
    logic [15:0] transitions;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_state_ctrl #(.DWELL_W(8), .CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .p_gb         (p_gb),
        .p_bg         (p_bg),
        .min_dwell    (min_dwell),
        .force_valid  (force_valid),
        .force_state  (force_state),
        .clear_stats  (clear_stats),
        .state        (state),
        .state_change (state_change),
        .bad_cycles   (bad_cycles),
        .transitions  (transitions)
    );

    typedef struct {
        logic        en;
        logic [15:0] pgb;
        logic [15:0] pbg;
        logic [7:0]  md;
        logic        fv;
        logic        fs;
        logic        clr;
        logic        e_state;
        logic        e_chg;
        logic [31:0] e_bad;
        logic [15:0] e_tr;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        enable = 1'b0; p_gb = 16'h0; p_bg = 16'h0; min_dwell = 8'd0;
        force_valid = 1'b0; force_state = 1'b1; clear_stats = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Sequence from reset; LFSR runs ACE1 -> E270 -> 7138 -> 389C on enabled cycles.
        vecs[0]  = '{1'b1, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0};
        vecs[1]  = '{1'b1, 16'hE26F, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0};
        vecs[2]  = '{1'b1, 16'h7138, 16'h0000, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0};
        vecs[3]  = '{1'b1, 16'hFFFF, 16'h0000, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 16'd1};
        vecs[4]  = '{1'b0, 16'h0000, 16'hFFFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd1};
        vecs[5]  = '{1'b1, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 16'd1};
        vecs[6]  = '{1'b1, 16'h0000, 16'h0000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 16'd1};
        vecs[7]  = '{1'b1, 16'h0000, 16'hFFFF, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 16'd1};
        vecs[8]  = '{1'b1, 16'h0000, 16'hFFFF, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd4, 16'd2};
        vecs[9]  = '{1'b1, 16'hFFFF, 16'h0000, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd4, 16'd2};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4, 16'd3};
        vecs[11] = '{1'b1, 16'h0000, 16'hFFFF, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 16'd0};
        vecs[12] = '{1'b1, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0};

        reset = 1'b1;
        idle_inputs();
        #12;
        check("reset_state", 32'(state), 32'd1);
        check("reset_chg", 32'(state_change), 32'd0);
        check("reset_bad", bad_cycles, 32'd0);
        check("reset_tr", 32'(transitions), 32'd0);
        check("reset_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            enable = vecs[i].en; p_gb = vecs[i].pgb; p_bg = vecs[i].pbg; min_dwell = vecs[i].md;
            force_valid = vecs[i].fv; force_state = vecs[i].fs; clear_stats = vecs[i].clr;
            step();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            check($sformatf("vec%0d_chg", i), 32'(state_change), 32'(vecs[i].e_chg));
            check($sformatf("vec%0d_bad", i), bad_cycles, vecs[i].e_bad);
            check($sformatf("vec%0d_tr", i), 32'(transitions), 32'(vecs[i].e_tr));
        end

        // Threshold exactly equal to the seed: transition on the first edge.
        idle_inputs(); do_reset();
        enable = 1'b1; p_gb = 16'hACE1;
        step();
        check("eq_seed_state", 32'(state), 32'd0);
        idle_inputs(); do_reset();
        enable = 1'b1; p_gb = 16'hACE0;
        step();
        check("below_seed_state", 32'(state), 32'd1);

        // p_gb = 0 never leaves GOOD.
        idle_inputs(); do_reset();
        enable = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            check("pgb0_state", 32'(state), 32'd1);
        end
        check("pgb0_tr", 32'(transitions), 32'd0);
        check("pgb0_bad", bad_cycles, 32'd0);

        // p_gb = FFFF, min_dwell = 0: single transition to BAD, one-cycle pulse.
        idle_inputs(); do_reset();
        enable = 1'b1; p_gb = 16'hFFFF;
        step();
        check("first_state", 32'(state), 32'd0);
        check("first_chg", 32'(state_change), 32'd1);
        step();
        check("first_chg_drop", 32'(state_change), 32'd0);
        check("first_state2", 32'(state), 32'd0);
        check("first_tr", 32'(transitions), 32'd1);

        // min_dwell = 10 with always-hit thresholds: toggle every 11 enabled cycles.
        idle_inputs(); do_reset();
        enable = 1'b1; p_gb = 16'hFFFF; p_bg = 16'hFFFF; min_dwell = 8'd10;
        for (int k = 1; k <= 110; k++) begin
            step();
            check("dwell_state", 32'(state), 32'(((k / 11) % 2) == 0));
        end
        check("dwell_tr", 32'(transitions), 32'd10);
        check("dwell_bad", bad_cycles, 32'd55);

        // Force while disabled: state moves, LFSR untouched.
        idle_inputs(); do_reset();
        force_valid = 1'b1; force_state = 1'b0;
        step();
        force_valid = 1'b0;
        check("force_state", 32'(state), 32'd0);
        check("force_chg", 32'(state_change), 32'd1);
        check("force_tr", 32'(transitions), 32'd1);
        check("force_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
        step();
        check("force_hold", 32'(state), 32'd0);
        check("force_bad_frozen", bad_cycles, 32'd0);

        // Async reset mid-run in BAD, then resume from seed.
        enable = 1'b1; p_bg = 16'h0;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_bad", bad_cycles, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        check("async_state", 32'(state), 32'd1);
        check("async_bad", bad_cycles, 32'd0);
        check("async_tr", 32'(transitions), 32'd0);
        check("async_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
        @(negedge clk);
        reset = 1'b0;
        p_gb = 16'hACE1;
        step();
        check("resume_state", 32'(state), 32'd0);
        check("resume_tr", 32'(transitions), 32'd1);

        // Transition counter saturation with a toggle every cycle.
        idle_inputs(); do_reset();
        enable = 1'b1; p_gb = 16'hFFFF; p_bg = 16'hFFFF;
        for (int i = 0; i < 65535; i++) step();
        check("sat_tr_reach", 32'(transitions), 32'hFFFF);
        for (int i = 0; i < 3; i++) step();
        check("sat_tr_hold", 32'(transitions), 32'hFFFF);
        check("sat_chg", 32'(state_change), 32'd1);
        check("sat_bad", bad_cycles, 32'd32769);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_state_ctrl.md
CHANNEL_STATE_CTRL -- requirements
Module: channel_state_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of minimum-dwell and dwell counters.
REQ-002 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-003 SHALL have port clk  input  1  clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  when high, advance the Markov chain one step this cycle.
REQ-006 SHALL have port p_gb  input  16  good->bad transition threshold.
REQ-007 SHALL have port p_bg  input  16  bad->good transition threshold.
REQ-008 SHALL have port min_dwell  input  DWELL_W  minimum enabled cycles spent in a state before a random transition.
REQ-009 SHALL have port force_valid  input  1  forced-state request strobe.
REQ-010 SHALL have port force_state  input  1  requested state (1=GOOD, 0=BAD).
REQ-011 SHALL have port clear_stats  input  1  synchronous clear of statistics counters.
REQ-012 SHALL have port state  output  1  registered channel state; 1=GOOD, 0=BAD; drives the AWGN channel state select.
REQ-013 SHALL have port state_change  output  1  one-cycle pulse, high in the first cycle a new state value is visible.
REQ-014 SHALL have port bad_cycles  output  CNT_W  count of enabled cycles with state=BAD.
REQ-015 SHALL have port transitions  output  16  count of state changes.

Function
REQ-016 SHALL implement a two-state FSM, GOOD and BAD; the state output SHALL equal the FSM register, with no extra latency.
REQ-017 SHALL contain a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing only on enabled cycles.
REQ-018 SHALL compare the current (pre-advance) LFSR value unsigned: in GOOD, transition if lfsr <= p_gb; in BAD, transition if lfsr <= p_bg.
REQ-019 SHALL therefore never make a random transition for a threshold of 0, and SHALL always make one for 16'hFFFF, because the LFSR is never zero.
REQ-020 SHALL allow a random transition only when enable=1 and dwell >= min_dwell; the transition takes effect at that clock edge.
REQ-021 SHALL clear dwell to 0 on every state entry and increment it on each enabled cycle without a transition, saturating at all-ones.
REQ-022 SHALL give min_dwell=0 a transition opportunity on every enabled cycle.
REQ-023 SHALL load force_state into the FSM at the next edge on force_valid=1, independent of enable, with priority over any random transition.
REQ-024 SHALL, on force_valid=1, clear dwell and leave the LFSR unadvanced unless enable=1.
REQ-025 SHALL treat a force to the current state as no state change: no state_change pulse, no transitions increment, but dwell still clears.
REQ-026 SHALL freeze the FSM, dwell and LFSR while enable=0, except for forcing.
REQ-027 SHALL increment bad_cycles on each enabled cycle where state=BAD.
REQ-028 SHALL increment transitions on each actual state change.
REQ-029 SHALL make both statistics counters saturate at all-ones.
REQ-030 SHALL give clear_stats priority over a simultaneous increment: counters read 0 next cycle, and the FSM transition still occurs.

Reset
REQ-031 SHALL apply the following on reset assertion, asynchronously: state=1 (GOOD), dwell=0, LFSR=16'hACE1, state_change=0, bad_cycles=0, transitions=0.
REQ-032 SHALL override any in-progress transition or force with a reset asserted mid-operation; operation resumes from the reset values on the first edge after release.

Structure
REQ-033 SHALL take from shared package chan_pkg: typedef enum logic {CH_BAD=1'b0, CH_GOOD=1'b1} chan_state_t, LFSR16_SEED=16'hACE1, and LFSR16_TAPS=16'hB400.
REQ-034 SHALL place the LFSR in sub-module lfsr16, with ports clk, reset, advance, and value[15:0].

Verification
REQ-035 SHALL cover: reset, enable=1, p_gb=0 for 1000 cycles -> state=1 throughout, transitions=0, bad_cycles=0.
REQ-036 SHALL cover: p_gb=16'hFFFF, min_dwell=0, enable=1 from reset -> state=0 after first edge, state_change high exactly 1 cycle, transitions=1.
REQ-037 SHALL cover: p_gb=p_bg=16'hFFFF, min_dwell=10, enable=1 -> state toggles every 11 cycles; after 110 cycles transitions=10, bad_cycles=55.
REQ-038 SHALL cover: enable=0, force_valid=1, force_state=0 for 1 cycle -> state=0 next cycle, transitions=1, LFSR still 16'hACE1.
REQ-039 SHALL cover: clear_stats=1 on the same cycle as a random transition -> counters 0 next cycle, state changed, state_change pulsed.
REQ-040 SHALL cover: reset asserted mid-run while state=0 -> state=1 and counters 0 without waiting for a clock edge.
